// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Basic datapath word and register-index types shared by the
//               pipeline stages of the five-stage MIPS core.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/data_path_muxs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_path_muxs_pkg
// Description : Shared datapath definitions: the EX/MEM data-memory request
//               state encoding and a small helper for memory-op decode.
// Revision    : 1.0 - initial release
// ============================================================================
package data_path_muxs_pkg;

    // Data-memory request sequencing in the EX/MEM register
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } ex_mem_state_t;

    // An op needs the data memory when it reads or writes it
    function automatic logic is_mem_op(input logic ren, input logic wen);
        return ren | wen;
    endfunction

endpackage : data_path_muxs_pkg
`default_nettype wire

// File: rtl/ex_mem_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_reg_if
// Description : Bundle of the EX/MEM pipeline register signals, seen from
//               the register itself through modport ex_mem_reg.
//               Counter signals exist only with EX_MEM_ACCESS_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_mem_reg_if;
    import cpu_types_pkg::*;

    // Hazard-unit strobes
    logic     enable_EX_MEM;
    logic     flush_EX_MEM;
    logic     mem_busy;

    // Execute-stage inputs
    logic     dREN_ID_EX;
    logic     dWEN_ID_EX;
    logic     WEN_ID_EX;
    logic     halt_ID_EX;
    regbits_t wsel_EX;
    word_t    alu_out_EX;
    word_t    rdat2_EX;
    word_t    npc_EX;

    // Data-memory side
    logic     dhit;
    word_t    dmemload;
    logic     dmemREN;
    logic     dmemWEN;
    word_t    dmemaddr;
    word_t    dmemstore;

    // Registered outputs toward MEM/WB
    logic     dREN_EX_MEM;
    logic     WEN_EX_MEM;
    logic     halt_EX_MEM;
    regbits_t wsel_EX_MEM;
    word_t    alu_out_EX_MEM;
    word_t    load_data_EX_MEM;
    word_t    npc_EX_MEM;

`ifdef EX_MEM_ACCESS_COUNT_EN
    word_t    load_count;
    word_t    store_count;
`endif

    modport ex_mem_reg (
        input  enable_EX_MEM, flush_EX_MEM,
        input  dREN_ID_EX, dWEN_ID_EX, WEN_ID_EX, halt_ID_EX,
        input  wsel_EX, alu_out_EX, rdat2_EX, npc_EX,
        input  dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_busy,
        output dREN_EX_MEM, WEN_EX_MEM, halt_EX_MEM, wsel_EX_MEM,
        output alu_out_EX_MEM, load_data_EX_MEM, npc_EX_MEM
`ifdef EX_MEM_ACCESS_COUNT_EN
        ,
        output load_count, store_count
`endif
    );

endinterface : ex_mem_reg_if
`default_nettype wire

// File: rtl/dmem_req_fsm.sv
`default_nettype none
// ============================================================================
// Module      : dmem_req_fsm
// Description : Data-memory request sequencer for the EX/MEM register.
//               Holds a load/store request until dhit, stalls upstream while
//               the access is outstanding, and defers a flush that arrives
//               mid-access until the access has completed.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_req_fsm
    import data_path_muxs_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic dREN,          // read request of the op being captured
    input  logic dWEN,          // write request of the op being captured
    input  logic dhit,
    input  logic capture,       // new op enters EX/MEM this edge
    input  logic flush,         // raw flush request from the hazard unit
    output logic ready,         // register may capture or flush this cycle
    output logic mem_busy,
    output logic dmemREN,
    output logic dmemWEN,
    output logic load_strobe,   // latch load data this edge
    output logic clear_strobe   // clear pipeline control fields this edge
);

    ex_mem_state_t r_state;
    ex_mem_state_t w_state_next;
    logic          r_pend_flush;
    logic          w_pend_flush_next;
    logic          r_ren;
    logic          r_wen;
    logic          w_in_req;

    assign w_in_req = (r_state == REQ);
    assign ready    = ~w_in_req;
    assign mem_busy = w_in_req & ~dhit;
    assign dmemREN  = w_in_req & r_ren;
    assign dmemWEN  = w_in_req & r_wen;

    // State, deferred-flush flag and the request type of the captured op
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_pend_flush <= 1'b0;
            r_ren        <= 1'b0;
            r_wen        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pend_flush <= w_pend_flush_next;
            if (capture && !w_in_req) begin
                r_ren <= dREN;
                r_wen <= dWEN;
            end else if (clear_strobe) begin
                r_ren <= 1'b0;
                r_wen <= 1'b0;
            end
        end
    end

    // Next state plus the load/clear strobes for the parent registers
    always_comb begin
        w_state_next      = r_state;
        w_pend_flush_next = r_pend_flush;
        load_strobe       = 1'b0;
        clear_strobe      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                // DONE lasts exactly one cycle and otherwise acts as IDLE
                if (flush) begin
                    clear_strobe = 1'b1;
                    w_state_next = IDLE;
                end else if (capture && is_mem_op(dREN, dWEN)) begin
                    w_state_next = REQ;
                end else begin
                    w_state_next = IDLE;
                end
            end
            REQ: begin
                if (dhit) begin
                    load_strobe = r_ren;
                    // A flush seen during the access takes effect only now,
                    // so a store is never abandoned halfway.
                    if (r_pend_flush || flush) begin
                        clear_strobe      = 1'b1;
                        w_pend_flush_next = 1'b0;
                        w_state_next      = IDLE;
                    end else begin
                        w_state_next = DONE;
                    end
                end else if (flush) begin
                    w_pend_flush_next = 1'b1;
                end
            end
            default: begin
                w_state_next      = IDLE;
                w_pend_flush_next = 1'b0;
            end
        endcase
    end

endmodule : dmem_req_fsm
`default_nettype wire

// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_reg
// Description : EX/MEM pipeline register of the five-stage MIPS datapath.
//               Captures execute results/control, issues the data-memory
//               request and returns registered results and load data.
//               Optional macro EX_MEM_ACCESS_COUNT_EN adds load/store
//               completion counters (load_count, store_count).
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_reg
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  logic     enable_EX_MEM,
    input  logic     flush_EX_MEM,
    input  logic     dREN_ID_EX,
    input  logic     dWEN_ID_EX,
    input  logic     WEN_ID_EX,
    input  logic     halt_ID_EX,
    input  regbits_t wsel_EX,
    input  word_t    alu_out_EX,
    input  word_t    rdat2_EX,
    input  word_t    npc_EX,
    input  logic     dhit,
    input  word_t    dmemload,
    output logic     dmemREN,
    output logic     dmemWEN,
    output word_t    dmemaddr,
    output word_t    dmemstore,
    output logic     mem_busy,
    output logic     dREN_EX_MEM,
    output logic     WEN_EX_MEM,
    output logic     halt_EX_MEM,
    output regbits_t wsel_EX_MEM,
    output word_t    alu_out_EX_MEM,
    output word_t    load_data_EX_MEM,
    output word_t    npc_EX_MEM
`ifdef EX_MEM_ACCESS_COUNT_EN
    ,
    output word_t    load_count,
    output word_t    store_count
`endif
);

    logic w_ready;
    logic w_capture;
    logic w_load_strobe;
    logic w_clear_strobe;

    // Enable is honoured only outside REQ; flush always wins over enable
    assign w_capture = enable_EX_MEM & ~flush_EX_MEM & w_ready;
    assign dmemaddr  = alu_out_EX_MEM;

    dmem_req_fsm u_dmem_req_fsm (
        .CLK          (CLK),
        .RST          (RST),
        .dREN         (dREN_ID_EX),
        .dWEN         (dWEN_ID_EX),
        .dhit         (dhit),
        .capture      (w_capture),
        .flush        (flush_EX_MEM),
        .ready        (w_ready),
        .mem_busy     (mem_busy),
        .dmemREN      (dmemREN),
        .dmemWEN      (dmemWEN),
        .load_strobe  (w_load_strobe),
        .clear_strobe (w_clear_strobe)
    );

    // Control fields: captured, cleared by a bubble; halt is sticky to RST
    always_ff @(posedge CLK) begin
        if (RST) begin
            dREN_EX_MEM <= 1'b0;
            WEN_EX_MEM  <= 1'b0;
            halt_EX_MEM <= 1'b0;
            wsel_EX_MEM <= '0;
        end else if (w_capture) begin
            dREN_EX_MEM <= dREN_ID_EX;
            WEN_EX_MEM  <= WEN_ID_EX;
            halt_EX_MEM <= halt_EX_MEM | halt_ID_EX;
            wsel_EX_MEM <= wsel_EX;
        end else if (w_clear_strobe) begin
            dREN_EX_MEM <= 1'b0;
            WEN_EX_MEM  <= 1'b0;
            wsel_EX_MEM <= '0;
        end
    end

    // Data fields: loaded on capture and held through bubbles
    always_ff @(posedge CLK) begin
        if (RST) begin
            alu_out_EX_MEM <= '0;
            npc_EX_MEM     <= '0;
            dmemstore      <= '0;
        end else if (w_capture) begin
            alu_out_EX_MEM <= alu_out_EX;
            npc_EX_MEM     <= npc_EX;
            dmemstore      <= rdat2_EX;
        end
    end

    // Load data is taken from memory on the completing dhit edge only
    always_ff @(posedge CLK) begin
        if (RST) begin
            load_data_EX_MEM <= '0;
        end else if (w_load_strobe) begin
            load_data_EX_MEM <= dmemload;
        end
    end

`ifdef EX_MEM_ACCESS_COUNT_EN
    logic w_store_done;

    // A store completes on the dhit edge of its own request
    assign w_store_done = dmemWEN & dhit;

    // Completed-access counters, free-running with natural wrap
    always_ff @(posedge CLK) begin
        if (RST) begin
            load_count  <= '0;
            store_count <= '0;
        end else begin
            if (w_load_strobe) begin
                load_count <= load_count + 32'd1;
            end
            if (w_store_done) begin
                store_count <= store_count + 32'd1;
            end
        end
    end
`endif

endmodule : ex_mem_reg
`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_reg
// Description : Directed self-checking bench for ex_mem_reg.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ex_mem_reg;

    logic        CLK;
    logic        RST;
    logic        enable_EX_MEM, flush_EX_MEM;
    logic        dREN_ID_EX, dWEN_ID_EX, WEN_ID_EX, halt_ID_EX;
    logic [4:0]  wsel_EX;
    logic [31:0] alu_out_EX, rdat2_EX, npc_EX;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN, mem_busy;
    logic [31:0] dmemaddr, dmemstore;
    logic        dREN_EX_MEM, WEN_EX_MEM, halt_EX_MEM;
    logic [4:0]  wsel_EX_MEM;
    logic [31:0] alu_out_EX_MEM, load_data_EX_MEM, npc_EX_MEM;
`ifdef EX_MEM_ACCESS_COUNT_EN
    logic [31:0] load_count, store_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ex_mem_reg dut (
        .CLK              (CLK),
        .RST              (RST),
        .enable_EX_MEM    (enable_EX_MEM),
        .flush_EX_MEM     (flush_EX_MEM),
        .dREN_ID_EX       (dREN_ID_EX),
        .dWEN_ID_EX       (dWEN_ID_EX),
        .WEN_ID_EX        (WEN_ID_EX),
        .halt_ID_EX       (halt_ID_EX),
        .wsel_EX          (wsel_EX),
        .alu_out_EX       (alu_out_EX),
        .rdat2_EX         (rdat2_EX),
        .npc_EX           (npc_EX),
        .dhit             (dhit),
        .dmemload         (dmemload),
        .dmemREN          (dmemREN),
        .dmemWEN          (dmemWEN),
        .dmemaddr         (dmemaddr),
        .dmemstore        (dmemstore),
        .mem_busy         (mem_busy),
        .dREN_EX_MEM      (dREN_EX_MEM),
        .WEN_EX_MEM       (WEN_EX_MEM),
        .halt_EX_MEM      (halt_EX_MEM),
        .wsel_EX_MEM      (wsel_EX_MEM),
        .alu_out_EX_MEM   (alu_out_EX_MEM),
        .load_data_EX_MEM (load_data_EX_MEM),
        .npc_EX_MEM       (npc_EX_MEM)
`ifdef EX_MEM_ACCESS_COUNT_EN
        ,
        .load_count       (load_count),
        .store_count      (store_count)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance one edge; outputs are then observed 1ns after it
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_in();
        enable_EX_MEM = 1'b0; flush_EX_MEM = 1'b0;
        dREN_ID_EX = 1'b0; dWEN_ID_EX = 1'b0; WEN_ID_EX = 1'b0; halt_ID_EX = 1'b0;
        wsel_EX = 5'd0; alu_out_EX = 32'd0; rdat2_EX = 32'd0; npc_EX = 32'd0;
        dhit = 1'b0; dmemload = 32'd0;
    endtask

    task automatic test_reset();
        clr_in();
        RST = 1'b1;
        tick();
        tick();
        n_checks++; if (dmemREN !== 1'b0 || dmemWEN !== 1'b0 || mem_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: ren=%b wen=%b busy=%b, expected 0 0 0", dmemREN, dmemWEN, mem_busy); end
        n_checks++; if ({dREN_EX_MEM, WEN_EX_MEM, halt_EX_MEM, wsel_EX_MEM} !== 8'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {dREN_EX_MEM, WEN_EX_MEM, halt_EX_MEM, wsel_EX_MEM}); end
        n_checks++; if (alu_out_EX_MEM !== 32'd0 || load_data_EX_MEM !== 32'd0 || npc_EX_MEM !== 32'd0 || dmemstore !== 32'd0) begin
            n_fail++; $display("FAIL reset_data: alu=%h ld=%h npc=%h st=%h expected 0", alu_out_EX_MEM, load_data_EX_MEM, npc_EX_MEM, dmemstore); end
        RST = 1'b0;
    endtask

    task automatic test_alu_op();
        enable_EX_MEM = 1'b1; WEN_ID_EX = 1'b1; wsel_EX = 5'd3; alu_out_EX = 32'h10; npc_EX = 32'h24;
        tick();
        clr_in();
        n_checks++; if (WEN_EX_MEM !== 1'b1 || wsel_EX_MEM !== 5'd3) begin
            n_fail++; $display("FAIL alu_ctrl: wen=%b wsel=%0d expected 1 3", WEN_EX_MEM, wsel_EX_MEM); end
        n_checks++; if (alu_out_EX_MEM !== 32'h10 || npc_EX_MEM !== 32'h24) begin
            n_fail++; $display("FAIL alu_data: alu=%h npc=%h expected 10 24", alu_out_EX_MEM, npc_EX_MEM); end
        n_checks++; if (mem_busy !== 1'b0 || dmemREN !== 1'b0) begin
            n_fail++; $display("FAIL alu_nobusy: busy=%b ren=%b expected 0 0", mem_busy, dmemREN); end
        tick();
        n_checks++; if (mem_busy !== 1'b0) begin
            n_fail++; $display("FAIL alu_nobusy2: busy=%b expected 0", mem_busy); end
    endtask

    task automatic test_load_latency();
        enable_EX_MEM = 1'b1; dREN_ID_EX = 1'b1; WEN_ID_EX = 1'b1; wsel_EX = 5'd5; alu_out_EX = 32'h100;
        tick();
        clr_in();
        for (int c = 0; c < 2; c++) begin
            n_checks++; if (dmemREN !== 1'b1 || dmemaddr !== 32'h100 || mem_busy !== 1'b1) begin
                n_fail++; $display("FAIL load_wait%0d: ren=%b addr=%h busy=%b expected 1 100 1", c, dmemREN, dmemaddr, mem_busy); end
            tick();
        end
        dhit = 1'b1; dmemload = 32'hDEADBEEF;
        #1;
        n_checks++; if (dmemREN !== 1'b1 || mem_busy !== 1'b0) begin
            n_fail++; $display("FAIL load_hit: ren=%b busy=%b expected 1 0", dmemREN, mem_busy); end
        tick();
        dhit = 1'b0; dmemload = 32'd0;
        n_checks++; if (load_data_EX_MEM !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL load_data: got %h expected deadbeef", load_data_EX_MEM); end
        n_checks++; if (dmemREN !== 1'b0 || dREN_EX_MEM !== 1'b1 || wsel_EX_MEM !== 5'd5) begin
            n_fail++; $display("FAIL load_done: ren=%b dren=%b wsel=%0d expected 0 1 5", dmemREN, dREN_EX_MEM, wsel_EX_MEM); end
        tick();
    endtask

    task automatic test_flush_store();
        enable_EX_MEM = 1'b1; dWEN_ID_EX = 1'b1; WEN_ID_EX = 1'b1; wsel_EX = 5'd7;
        alu_out_EX = 32'h200; rdat2_EX = 32'h55;
        tick();
        clr_in();
        n_checks++; if (dmemWEN !== 1'b1 || dmemstore !== 32'h55 || dmemaddr !== 32'h200) begin
            n_fail++; $display("FAIL store_req: wen=%b st=%h addr=%h expected 1 55 200", dmemWEN, dmemstore, dmemaddr); end
        flush_EX_MEM = 1'b1;
        tick();
        flush_EX_MEM = 1'b0;
        n_checks++; if (dmemWEN !== 1'b1 || mem_busy !== 1'b1 || WEN_EX_MEM !== 1'b1) begin
            n_fail++; $display("FAIL store_pend: dwen=%b busy=%b wen=%b expected 1 1 1", dmemWEN, mem_busy, WEN_EX_MEM); end
        dhit = 1'b1;
        #1;
        n_checks++; if (dmemWEN !== 1'b1 || mem_busy !== 1'b0) begin
            n_fail++; $display("FAIL store_hit: dwen=%b busy=%b expected 1 0", dmemWEN, mem_busy); end
        tick();
        dhit = 1'b0;
        n_checks++; if (WEN_EX_MEM !== 1'b0 || dREN_EX_MEM !== 1'b0 || wsel_EX_MEM !== 5'd0 || dmemWEN !== 1'b0) begin
            n_fail++; $display("FAIL store_flushed: wen=%b dren=%b wsel=%0d dwen=%b expected 0 0 0 0", WEN_EX_MEM, dREN_EX_MEM, wsel_EX_MEM, dmemWEN); end
        n_checks++; if (dmemstore !== 32'h55 || alu_out_EX_MEM !== 32'h200) begin
            n_fail++; $display("FAIL store_datahold: st=%h alu=%h expected 55 200", dmemstore, alu_out_EX_MEM); end
    endtask

    task automatic test_enable_flush();
        enable_EX_MEM = 1'b1; WEN_ID_EX = 1'b1; wsel_EX = 5'd9; alu_out_EX = 32'h77;
        tick();
        enable_EX_MEM = 1'b1; flush_EX_MEM = 1'b1; dREN_ID_EX = 1'b1; WEN_ID_EX = 1'b1;
        wsel_EX = 5'd12; alu_out_EX = 32'h300;
        tick();
        clr_in();
        n_checks++; if ({dREN_EX_MEM, WEN_EX_MEM, halt_EX_MEM, wsel_EX_MEM} !== 8'd0 || dmemREN !== 1'b0) begin
            n_fail++; $display("FAIL bubble_ctrl: got %b ren=%b expected 0", {dREN_EX_MEM, WEN_EX_MEM, halt_EX_MEM, wsel_EX_MEM}, dmemREN); end
        n_checks++; if (alu_out_EX_MEM !== 32'h77) begin
            n_fail++; $display("FAIL bubble_datahold: alu=%h expected 77", alu_out_EX_MEM); end
    endtask

    task automatic test_halt_and_reset();
        enable_EX_MEM = 1'b1; halt_ID_EX = 1'b1;
        tick();
        clr_in();
        n_checks++; if (halt_EX_MEM !== 1'b1) begin
            n_fail++; $display("FAIL halt_set: got %b expected 1", halt_EX_MEM); end
        flush_EX_MEM = 1'b1;
        tick();
        flush_EX_MEM = 1'b0;
        n_checks++; if (halt_EX_MEM !== 1'b1) begin
            n_fail++; $display("FAIL halt_flush: got %b expected 1", halt_EX_MEM); end
        enable_EX_MEM = 1'b1; dREN_ID_EX = 1'b1; alu_out_EX = 32'h400;
        tick();
        clr_in();
        n_checks++; if (halt_EX_MEM !== 1'b1 || dmemREN !== 1'b1) begin
            n_fail++; $display("FAIL halt_sticky_req: halt=%b ren=%b expected 1 1", halt_EX_MEM, dmemREN); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_checks++; if (dmemREN !== 1'b0 || mem_busy !== 1'b0 || halt_EX_MEM !== 1'b0 || dREN_EX_MEM !== 1'b0) begin
            n_fail++; $display("FAIL rst_midreq: ren=%b busy=%b halt=%b dren=%b expected 0", dmemREN, mem_busy, halt_EX_MEM, dREN_EX_MEM); end
        n_checks++; if (alu_out_EX_MEM !== 32'd0 || load_data_EX_MEM !== 32'd0 || dmemaddr !== 32'd0) begin
            n_fail++; $display("FAIL rst_middata: alu=%h ld=%h addr=%h expected 0", alu_out_EX_MEM, load_data_EX_MEM, dmemaddr); end
    endtask

    task automatic test_back_to_back();
        enable_EX_MEM = 1'b1; dREN_ID_EX = 1'b1; wsel_EX = 5'd2; alu_out_EX = 32'h500;
        tick();
        clr_in();
        dhit = 1'b1; dmemload = 32'hCAFEF00D;
        #1;
        n_checks++; if (dmemREN !== 1'b1 || mem_busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_hit: ren=%b busy=%b expected 1 0", dmemREN, mem_busy); end
        tick();
        clr_in();
        n_checks++; if (load_data_EX_MEM !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL b2b_data: got %h expected cafef00d", load_data_EX_MEM); end
        enable_EX_MEM = 1'b1; WEN_ID_EX = 1'b1; wsel_EX = 5'd4; alu_out_EX = 32'h600;
        tick();
        clr_in();
        n_checks++; if (alu_out_EX_MEM !== 32'h600 || wsel_EX_MEM !== 5'd4 || dREN_EX_MEM !== 1'b0 || dmemREN !== 1'b0) begin
            n_fail++; $display("FAIL b2b_capture: alu=%h wsel=%0d dren=%b ren=%b expected 600 4 0 0", alu_out_EX_MEM, wsel_EX_MEM, dREN_EX_MEM, dmemREN); end
        dhit = 1'b1; dmemload = 32'h1111;
        tick();
        clr_in();
        n_checks++; if (load_data_EX_MEM !== 32'hCAFEF00D || dmemREN !== 1'b0) begin
            n_fail++; $display("FAIL idle_dhit: ld=%h ren=%b expected cafef00d 0", load_data_EX_MEM, dmemREN); end
    endtask

`ifdef EX_MEM_ACCESS_COUNT_EN
    task automatic test_counters();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            enable_EX_MEM = 1'b1;
            dREN_ID_EX = (k != 2);
            dWEN_ID_EX = (k == 2);
            alu_out_EX = 32'h10 + 32'(k);
            tick();
            clr_in();
            dhit = 1'b1;
            tick();
            dhit = 1'b0;
        end
        n_checks++; if (load_count !== 32'd2 || store_count !== 32'd1) begin
            n_fail++; $display("FAIL counters: loads=%0d stores=%0d expected 2 1", load_count, store_count); end
    endtask
`endif

    initial begin
        clr_in();
        RST = 1'b1;
        test_reset();
        test_alu_op();
        test_load_latency();
        test_flush_store();
        test_enable_flush();
        test_halt_and_reset();
        test_back_to_back();
`ifdef EX_MEM_ACCESS_COUNT_EN
        test_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ex_mem_reg
`default_nettype wire
